// File: rtl/systolic_operand_feeder.sv
// Operand feeder for an NxN output-stationary MAC array: diagonally skews A columns / B rows onto
// the array edges, then zero-flushes. Optional stall counter enabled by defining FEEDER_STALL_CNT_EN.
module systolic_operand_feeder #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [15:0]    k_len,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] a_col,
  input  logic [N*W-1:0] b_row,
  output logic [N*W-1:0] left_edge,
  output logic [N*W-1:0] top_edge,
  output logic           pe_clear,
  output logic           busy,
  output logic           done,
  output logic [15:0]    stall_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DONE} state_t;

  // Flush covers skew drain, array propagation and the final accumulate.
  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 2);

  state_t        state;
  logic [15:0]   k_lat;
  logic [15:0]   beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic          accept;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k_lat     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      in_ready  <= 1'b0;
      pe_clear  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pe_clear <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CLEAR;
            k_lat    <= k_len;
            pe_clear <= 1'b1;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          beat_cnt  <= '0;
          flush_cnt <= '0;
          if (k_lat == 16'd0) begin
            state <= FLUSH;
          end else begin
            state    <= STREAM;
            in_ready <= 1'b1;
          end
        end
        STREAM: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 16'd1;
            if (beat_cnt + 16'd1 == k_lat) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Lane i has i+1 stages; non-accepting cycles inject MAC-neutral zeros.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [W-1:0] a_dly [0:i];
    logic [W-1:0] b_dly [0:i];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s <= i; s++) begin
          a_dly[s] <= '0;
          b_dly[s] <= '0;
        end
      end else begin
        a_dly[0] <= accept ? a_col[i*W +: W] : '0;
        b_dly[0] <= accept ? b_row[i*W +: W] : '0;
        for (int s = 1; s <= i; s++) begin
          a_dly[s] <= a_dly[s-1];
          b_dly[s] <= b_dly[s-1];
        end
      end
    end

    assign left_edge[i*W +: W] = a_dly[i];
    assign top_edge[i*W +: W]  = b_dly[i];
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;

  // Zeroed as the tile begins so it reads 0 while pe_clear is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state == IDLE && start) begin
      stall_q <= '0;
    end else if (state == STREAM && !in_valid && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Self-checking bench for systolic_operand_feeder: table-driven tiles, random tiles and a
// behavioural output-stationary array that must end up holding A*B when done pulses.
module tb_systolic_operand_feeder;

  localparam int N = 4;
  localparam int W = 32;
  localparam int MAXC = 512;
  localparam int MAXK = 32;
  localparam int FLUSH_CYC = 2 * (N - 1) + 1;
`ifdef FEEDER_STALL_CNT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           start;
  logic [15:0]    k_len;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] a_col;
  logic [N*W-1:0] b_row;
  logic [N*W-1:0] left_edge;
  logic [N*W-1:0] top_edge;
  logic           pe_clear;
  logic           busy;
  logic           done;
  logic [15:0]    stall_cnt;

  systolic_operand_feeder #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_col(a_col), .b_row(b_row),
    .left_edge(left_edge), .top_edge(top_edge),
    .pe_clear(pe_clear), .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] bt_a [MAXK][N];
  logic [W-1:0] bt_b [MAXK][N];
  bit           acc_flag [MAXC];
  int           acc_idx [MAXC];
  bit           drv_valid [MAXC];

  // Behavioural output-stationary array fed by the DUT edges, reset by rst or pe_clear.
  logic [W-1:0] pa [N][N];
  logic [W-1:0] pb [N][N];
  logic [W-1:0] acc [N][N];

  function automatic logic [W-1:0] a_in_of(int i, int j);
    if (j == 0) return left_edge[i*W +: W];
    return pa[i][j-1];
  endfunction

  function automatic logic [W-1:0] b_in_of(int i, int j);
    if (i == 0) return top_edge[j*W +: W];
    return pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst || pe_clear) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j]  <= a_in_of(i, j);
          pb[i][j]  <= b_in_of(i, j);
          acc[i][j] <= acc[i][j] + a_in_of(i, j) * b_in_of(i, j);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic s, input logic [15:0] kl, input logic v,
                                input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    start    = s;
    k_len    = kl;
    in_valid = v;
    a_col    = a;
    b_row    = b;
  endtask

  function automatic logic [N*W-1:0] rand_bus();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = $urandom;
    return v;
  endfunction

  // Cycle r=0 presents start, r=1 is the clear cycle, streaming starts at r=2.
  task automatic run_tile(input int k, input logic [15:0] mask, input int mode, input int poke_r,
                          output int done_seen, output logic [15:0] stall_seen);
    int last_r, done_r, nb, stalls, src;
    logic [N*W-1:0] exp_l, exp_t, da, db;
    logic [W-1:0] cexp;
    done_seen  = -1;
    stall_seen = '0;
    for (int b = 0; b < k; b++) begin
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: begin
            bt_a[b][i] = (i == b % N) ? 32'd1 : 32'd0;
            bt_b[b][i] = W'(b * N + i + 1);
          end
          1: begin
            bt_a[b][i] = (i == 0) ? 32'hFFFF_FFFF : (i == N - 1) ? 32'h8000_0000 : $urandom;
            bt_b[b][i] = (i == 0) ? 32'hFFFF_FFFF : (i == N - 1) ? 32'h8000_0000 : $urandom;
          end
          default: begin
            bt_a[b][i] = $urandom;
            bt_b[b][i] = $urandom;
          end
        endcase
      end
    end
    for (int r = 0; r < MAXC; r++) begin
      acc_flag[r]  = 1'b0;
      acc_idx[r]   = 0;
      drv_valid[r] = 1'b0;
    end
    nb = 0;
    last_r = 1;
    stalls = 0;
    for (int r = 2; r < MAXC && nb < k; r++) begin
      drv_valid[r] = mask[(r - 2) % 16];
      if (drv_valid[r]) begin
        acc_flag[r] = 1'b1;
        acc_idx[r]  = nb;
        nb++;
        last_r = r;
      end else begin
        stalls++;
      end
    end
    done_r = last_r + FLUSH_CYC + 1;
    for (int r = last_r + 1; r < done_r + 1; r++) drv_valid[r] = 1'($urandom_range(0, 1));

    for (int r = 0; r <= done_r + 1; r++) begin
      @(negedge clk);
      exp_l = '0;
      exp_t = '0;
      for (int i = 0; i < N; i++) begin
        src = r - 1 - i;
        if (src >= 0 && acc_flag[src]) begin
          exp_l[i*W +: W] = bt_a[acc_idx[src]][i];
          exp_t[i*W +: W] = bt_b[acc_idx[src]][i];
        end
      end
      check_output("left_edge", left_edge, exp_l);
      check_output("top_edge", top_edge, exp_t);
      check_output("in_ready", in_ready, (k > 0 && r >= 2 && r <= last_r));
      check_output("busy", busy, (r >= 1 && r <= done_r));
      check_output("pe_clear", pe_clear, (r == 1));
      check_output("done", done, (r == done_r));
      if (done && done_seen < 0) done_seen = r;
      if (r == done_r) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            cexp = '0;
            for (int b = 0; b < k; b++) cexp = cexp + bt_a[b][i] * bt_b[b][j];
            check_output($sformatf("array_val[%0d][%0d]", i, j), acc[i][j], cexp);
          end
        end
        stall_seen = stall_cnt;
        check_output("stall_cnt_model", stall_cnt, STALL_ON ? stalls : 0);
      end
      da = rand_bus();
      db = rand_bus();
      if (acc_flag[r]) begin
        for (int i = 0; i < N; i++) begin
          da[i*W +: W] = bt_a[acc_idx[r]][i];
          db[i*W +: W] = bt_b[acc_idx[r]][i];
        end
      end
      apply_stimulus((r == 0) || (r == poke_r), (r == 0) ? k[15:0] : 16'($urandom),
                     (r <= done_r) ? drv_valid[r] : 1'b0, da, db);
    end
  endtask

  typedef struct {
    int          k;
    logic [15:0] mask;
    int          mode;
    int          poke;
    int          exp_done;
    int          exp_stall;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int dr;
    logic [15:0] st;
    int rk;
    logic [15:0] rmask;

    vecs[0] = '{k: 4, mask: 16'hFFFF, mode: 0, poke: 0, exp_done: 13, exp_stall: 0};
    vecs[1] = '{k: 4, mask: 16'h5555, mode: 0, poke: 0, exp_done: 16, exp_stall: 3};
    vecs[2] = '{k: 0, mask: 16'hFFFF, mode: 0, poke: 0, exp_done: 9,  exp_stall: 0};
    vecs[3] = '{k: 8, mask: 16'hFFFF, mode: 2, poke: 5, exp_done: 17, exp_stall: 0};
    vecs[4] = '{k: 4, mask: 16'hFFFF, mode: 1, poke: 0, exp_done: 13, exp_stall: 0};
    vecs[5] = '{k: 3, mask: 16'h0006, mode: 2, poke: 0, exp_done: 27, exp_stall: 15};

    rst = 1'b1;
    apply_stimulus(1'b0, 16'd0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    check_output("reset_in_ready", in_ready, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_done", done, 0);
    check_output("reset_pe_clear", pe_clear, 0);
    check_output("reset_left_edge", left_edge, 0);
    check_output("reset_top_edge", top_edge, 0);
    check_output("reset_stall_cnt", stall_cnt, 0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      run_tile(vecs[v].k, vecs[v].mask, vecs[v].mode, vecs[v].poke, dr, st);
      check_output($sformatf("done_cycle_vec%0d", v), dr, vecs[v].exp_done);
      check_output($sformatf("stall_vec%0d", v), st, STALL_ON ? vecs[v].exp_stall : 0);
    end

    // Reset while beat 2 of a four-beat tile is being accepted.
    @(negedge clk);
    apply_stimulus(1'b1, 16'd4, 1'b0, '0, '0);
    @(negedge clk);
    apply_stimulus(1'b0, 16'd0, 1'b0, '0, '0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      if (b == 2) rst = 1'b1;
      apply_stimulus(1'b0, 16'd0, 1'b1, rand_bus(), rand_bus());
    end
    @(negedge clk);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_in_ready", in_ready, 0);
    check_output("midrst_left_edge", left_edge, 0);
    check_output("midrst_top_edge", top_edge, 0);
    check_output("midrst_done", done, 0);
    check_output("midrst_pe_clear", pe_clear, 0);
    check_output("midrst_stall_cnt", stall_cnt, 0);
    rst = 1'b0;
    apply_stimulus(1'b0, 16'd0, 1'b0, '0, '0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check_output("midrst_no_done", done, 0);
      check_output("midrst_idle", busy, 0);
    end
    run_tile(4, 16'hFFFF, 0, 0, dr, st);
    check_output("post_rst_done_cycle", dr, 13);

    for (int t = 0; t < 5; t++) begin
      rk = $urandom_range(1, 12);
      rmask = 16'($urandom) | 16'h0001;
      run_tile(rk, rmask, 2, ($urandom_range(0, 1) == 1) ? 2 : 0, dr, st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
